// File: rtl/driver_arbiter.sv
// Two-source ownership arbiter: exactly one requester drives out_sig at a time,
// ties alternate after a minimum tenure, and contention episodes are flagged and counted.
//
// state    | meaning
// ST_IDLE  | nobody owns the output; out_sig holds its last value
// ST_OWN_A | source A owns the output
// ST_OWN_B | source B owns the output
module driver_arbiter #(
    parameter int WIDTH       = 1,
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             grant_a,
    output logic             grant_b,
    output logic [WIDTH-1:0] out_sig,
    output logic             out_valid,
    output logic             conflict,
    output logic [CNT_W-1:0] conflict_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN_A = 2'd1;
    localparam logic [1:0] ST_OWN_B = 2'd2;

    // A one-cycle hold still needs a 1-bit tenure register; it simply stays at 0.
    localparam int TEN_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TEN_W-1:0] TEN_FULL = TEN_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             last_owner_b;
    logic [TEN_W-1:0] tenure;
    logic             full;
    logic             entering;
    logic             both;
    logic             both_q;
    logic             both_rise;

    assign full      = (tenure == TEN_FULL);
    assign both      = req_a & req_b;
    assign both_rise = both & ~both_q;
    assign grant_a   = (state == ST_OWN_A);
    assign grant_b   = (state == ST_OWN_B);
    assign entering  = (state_nxt != state) && (state_nxt != ST_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (both)
                    state_nxt = last_owner_b ? ST_OWN_A : ST_OWN_B;
                else if (req_a)
                    state_nxt = ST_OWN_A;
                else if (req_b)
                    state_nxt = ST_OWN_B;
            end
            ST_OWN_A: begin
                if (!req_a)
                    state_nxt = req_b ? ST_OWN_B : ST_IDLE;
                else if (req_b && full)
                    state_nxt = ST_OWN_B;
            end
            ST_OWN_B: begin
                if (!req_b)
                    state_nxt = req_a ? ST_OWN_A : ST_IDLE;
                else if (req_a && full)
                    state_nxt = ST_OWN_A;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            last_owner_b <= 1'b1;
            tenure       <= '0;
        end else begin
            state <= state_nxt;
            if (entering) begin
                tenure       <= '0;
                last_owner_b <= (state_nxt == ST_OWN_B);
            end else if (state != ST_IDLE && !full) begin
                tenure <= tenure + 1'b1;
            end
        end
    end

    // Output register follows the grant seen during the cycle, so data lags the grant by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_sig   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (grant_a)
                out_sig <= data_a;
            else if (grant_b)
                out_sig <= data_b;
            out_valid <= grant_a | grant_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            both_q         <= 1'b0;
            conflict       <= 1'b0;
            conflict_count <= '0;
        end else begin
            both_q   <= both;
            conflict <= both_rise;
            if (both_rise && conflict_count != CNT_MAX)
                conflict_count <= conflict_count + 1'b1;
        end
    end

endmodule
